// File: rtl/stoch_scale_array_pkg.sv
// Shared definitions for the stochastic bit-stream scaler.
//   MAGNIFY / ATTENUATE : values of the MODE input
//   widths_ok()         : credit register must be able to hold any gain value
package stoch_scale_array_pkg;

   localparam logic MAGNIFY   = 1'b0;
   localparam logic ATTENUATE = 1'b1;

   function automatic bit widths_ok(input int cw, input int gw);
      return cw >= gw;
   endfunction

endpackage

// File: rtl/stoch_scale_lane.sv
// One lane of the stochastic scaler.
//   CLK, RST    : clock, asynchronous active-high reset
//   EN          : low freezes the credit register and forces OUT/SAT low
//   FLUSH       : mode change in progress, clear credit, emit nothing
//   MODE        : registered mode (0 magnify, 1 attenuate)
//   G           : shared gain
//   IN          : input stochastic bit
//   OUT, SAT    : registered output bit, saturation pulse (magnify only)
module stoch_scale_lane
   import stoch_scale_array_pkg::*;
#(
   parameter int GW = 4,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          FLUSH,
   input  logic          MODE,
   input  logic [GW-1:0] G,
   input  logic          IN,
   output logic          OUT,
   output logic          SAT
);

   localparam logic [CW:0]   ONE_W = {{CW{1'b0}}, 1'b1};
   localparam logic [GW-1:0] ONE_G = {{(GW-1){1'b0}}, 1'b1};

   logic [CW-1:0] c, c_nxt;
   logic          out_nxt, sat_nxt;
   logic [CW:0]   g_ext, t, tm1, cinc;

   always_comb begin
      g_ext   = {{(CW+1-GW){1'b0}}, G};
      // One bit wider than the credit so an overflowing sum is visible.
      t       = {1'b0, c} + (IN ? g_ext : '0);
      tm1     = t - ONE_W;
      cinc    = {1'b0, c} + ONE_W;
      c_nxt   = c;
      out_nxt = 1'b0;
      sat_nxt = 1'b0;
      if (!EN) begin
         c_nxt = c;
      end else if (FLUSH) begin
         c_nxt = '0;
      end else if (MODE == MAGNIFY) begin
         if (t != '0) begin
            out_nxt = 1'b1;
            // tm1[CW] set means the remaining credit no longer fits: clip.
            if (tm1[CW]) begin
               c_nxt   = '1;
               sat_nxt = 1'b1;
            end else begin
               c_nxt = tm1[CW-1:0];
            end
         end
      end else begin
         if (G <= ONE_G) begin
            out_nxt = IN;
            c_nxt   = '0;
         end else if (IN) begin
            // >= rather than == so a gain lowered mid-count terminates
            // immediately instead of wrapping the counter.
            if (cinc >= g_ext) begin
               out_nxt = 1'b1;
               c_nxt   = '0;
            end else begin
               c_nxt = cinc[CW-1:0];
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c   <= '0;
         OUT <= 1'b0;
         SAT <= 1'b0;
      end else begin
         c   <= c_nxt;
         OUT <= out_nxt;
         SAT <= sat_nxt;
      end
   end

endmodule

// File: rtl/stoch_scale_array.sv
// N-lane temporal stochastic bit-stream scaler with shared gain and mode.
//   CLK, RST : clock, asynchronous active-high reset
//   EN       : global enable
//   MODE     : 0 magnify (stretch each '1' into G ones), 1 attenuate (1 per G)
//   G        : shared unsigned gain
//   IN       : one stochastic input bit per lane
//   OUT      : registered scaled bits
//   SAT      : per-lane credit-clip pulse
module stoch_scale_array
   import stoch_scale_array_pkg::*;
#(
   parameter int N  = 8,
   parameter int GW = 4,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          MODE,
   input  logic [GW-1:0] G,
   input  logic [N-1:0]  IN,
   output logic [N-1:0]  OUT,
   output logic [N-1:0]  SAT
);

   if (!widths_ok(CW, GW)) begin : g_bad_widths
      $error("stoch_scale_array: CW must be >= GW");
   end

   logic mode_q;
   logic flush;

   // A mode change spends one enabled cycle clearing every lane.
   assign flush = EN & (MODE != mode_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)        mode_q <= MAGNIFY;
      else if (flush) mode_q <= MODE;
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      stoch_scale_lane #(.GW(GW), .CW(CW)) u_lane (
         .CLK   (CLK),
         .RST   (RST),
         .EN    (EN),
         .FLUSH (flush),
         .MODE  (mode_q),
         .G     (G),
         .IN    (IN[i]),
         .OUT   (OUT[i]),
         .SAT   (SAT[i])
      );
   end

endmodule

// File: tb/tb_stoch_scale_array.sv
module tb_stoch_scale_array;

   localparam int N    = 8;
   localparam int GW   = 4;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST;
   logic          EN;
   logic          MODE;
   logic [GW-1:0] G;
   logic [N-1:0]  IN;
   logic [N-1:0]  OUT;
   logic [N-1:0]  SAT;

   stoch_scale_array #(.N(N), .GW(GW), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .G(G),
      .IN(IN), .OUT(OUT), .SAT(SAT)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: per-lane credit as a plain integer.
   int         cr [N];
   bit         mq;
   logic [N-1:0] eo, es;

   task automatic mreset();
      for (int l = 0; l < N; l++) cr[l] = 0;
      mq = 1'b0;
      eo = '0;
      es = '0;
   endtask

   task automatic mstep();
      int t;
      eo = '0;
      es = '0;
      if (!EN) begin
         eo = '0;
      end else if (MODE != mq) begin
         for (int l = 0; l < N; l++) cr[l] = 0;
         mq = MODE;
      end else if (!mq) begin
         for (int l = 0; l < N; l++) begin
            t = cr[l] + (IN[l] ? int'(G) : 0);
            if (t > 0) begin
               eo[l] = 1'b1;
               if (t - 1 > CMAX) begin
                  cr[l] = CMAX;
                  es[l] = 1'b1;
               end else begin
                  cr[l] = t - 1;
               end
            end
         end
      end else begin
         for (int l = 0; l < N; l++) begin
            if (G <= 1) begin
               eo[l] = IN[l];
               cr[l] = 0;
            end else if (IN[l]) begin
               if (cr[l] + 1 >= int'(G)) begin
                  eo[l] = 1'b1;
                  cr[l] = 0;
               end else begin
                  cr[l] = cr[l] + 1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=[%0d..%0d]", name, act, lo, hi);
      end
   endtask

   // One clock: advance the model, clock the DUT, compare just after the edge.
   task automatic cyc();
      mstep();
      @(posedge CLK);
      #1;
      chk("out", OUT, eo);
      chk("sat", SAT, es);
   endtask

   // Two mode changes in a row leave every lane at zero credit in mode m.
   task automatic flush_to(input logic m);
      EN = 1'b1; IN = '0; MODE = ~m;
      cyc();
      MODE = m;
      cyc();
   endtask

   typedef struct packed {
      logic          en;
      logic          mode;
      logic [GW-1:0] g;
      logic [N-1:0]  in;
      logic [N-1:0]  out;
      logic [N-1:0]  sat;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int cnt, cnt2, ones;
      int pos [N];
      logic [N-1:0] prev;

      tbl[0]  = '{1'b1, 1'b0, 4'd3, 8'h01, 8'h01, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 4'd3, 8'h00, 8'h01, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 4'd3, 8'h00, 8'h01, 8'h00};
      tbl[3]  = '{1'b1, 1'b0, 4'd3, 8'h00, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 1'b0, 4'd3, 8'hff, 8'h00, 8'h00};
      tbl[5]  = '{1'b1, 1'b1, 4'd4, 8'hff, 8'h00, 8'h00};
      tbl[6]  = '{1'b1, 1'b1, 4'd4, 8'hff, 8'h00, 8'h00};
      tbl[7]  = '{1'b1, 1'b1, 4'd4, 8'hff, 8'h00, 8'h00};
      tbl[8]  = '{1'b1, 1'b1, 4'd4, 8'hff, 8'h00, 8'h00};
      tbl[9]  = '{1'b1, 1'b1, 4'd4, 8'hff, 8'hff, 8'h00};
      tbl[10] = '{1'b1, 1'b1, 4'd1, 8'h5a, 8'h5a, 8'h00};
      tbl[11] = '{1'b1, 1'b1, 4'd0, 8'ha5, 8'ha5, 8'h00};
      tbl[12] = '{1'b1, 1'b0, 4'd2, 8'hff, 8'h00, 8'h00};
      tbl[13] = '{1'b1, 1'b0, 4'd2, 8'h0f, 8'h0f, 8'h00};
      tbl[14] = '{1'b1, 1'b0, 4'd2, 8'h00, 8'h0f, 8'h00};
      tbl[15] = '{1'b1, 1'b0, 4'd2, 8'h00, 8'h00, 8'h00};

      RST = 1'b1; EN = 1'b0; MODE = 1'b0; G = '0; IN = '0;
      mreset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_out", OUT, 8'h00);
      chk("reset_sat", SAT, 8'h00);
      RST = 1'b0;

      // Directed table starting from the reset state.
      for (int i = 0; i < 16; i++) begin
         EN = tbl[i].en; MODE = tbl[i].mode; G = tbl[i].g; IN = tbl[i].in;
         mstep();
         @(posedge CLK);
         #1;
         chk($sformatf("tbl%0d_out", i), OUT, tbl[i].out);
         chk($sformatf("tbl%0d_sat", i), SAT, tbl[i].sat);
      end

      // Magnify G=3, single pulse on lane 0 at step 5.
      flush_to(1'b0);
      G = 4'd3;
      for (int k = 1; k <= 10; k++) begin
         IN = (k == 5) ? 8'h01 : 8'h00;
         cyc();
         chk("mag_pulse", OUT, (k >= 5 && k <= 7) ? 8'h01 : 8'h00);
      end

      // Saturation on lane 1.
      flush_to(1'b0);
      G = 4'd15; cnt = 0;
      for (int k = 0; k < 40; k++) begin
         IN = 8'h02;
         cyc();
         if (SAT[1]) cnt++;
      end
      chk_int("sat_pulses", cnt, 22, 22);
      IN = '0; cnt = 0;
      for (int k = 0; k < 260; k++) begin
         cyc();
         if (OUT[1]) cnt++;
      end
      chk_int("sat_drain", cnt, 255, 255);

      // Attenuate G=4 with constant ones, then G=1 pass-through.
      flush_to(1'b1);
      G = 4'd4; cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         IN = 8'hff;
         cyc();
         chk("att_g4", OUT, (k % 4 == 0) ? 8'hff : 8'h00);
         if (OUT[3]) cnt++;
      end
      chk_int("att_g4_count", cnt, 4, 4);
      G = 4'd1; prev = '0;
      for (int k = 0; k < 8; k++) begin
         IN = N'($urandom);
         prev = IN;
         cyc();
         chk("att_g1", OUT, prev);
      end

      // Mode change with credit pending.
      flush_to(1'b0);
      G = 4'd6; IN = 8'h01;
      cyc();
      MODE = 1'b1; G = 4'd4; IN = 8'hff;
      cyc();
      chk("flush_dead", OUT, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk("flush_att", OUT, (k == 4) ? 8'hff : 8'h00);
      end

      // Asynchronous reset with ~56 credit in every lane.
      flush_to(1'b0);
      G = 4'd15; IN = 8'hff;
      repeat (4) cyc();
      IN = '0;
      #2 RST = 1'b1;
      #1;
      chk("async_rst_out", OUT, 8'h00);
      chk("async_rst_sat", SAT, 8'h00);
      @(posedge CLK);
      #1 RST = 1'b0;
      mreset();
      EN = 1'b0; IN = 8'hff;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("en_low", OUT, 8'h00);
      end

      // Randomized stimulus against the model.
      for (int k = 0; k < 2000; k++) begin
         EN = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) MODE = ~MODE;
         G  = GW'($urandom);
         IN = N'($urandom);
         cyc();
      end

      // Density: exactly one '1' per lane in every 10-cycle block (p = 0.1).
      for (int m = 0; m < 2; m++) begin
         flush_to(m[0]);
         G = 4'd4; ones = 0;
         for (int b = 0; b < 1000; b++) begin
            for (int l = 0; l < N; l++) pos[l] = $urandom_range(0, 9);
            for (int j = 0; j < 10; j++) begin
               for (int l = 0; l < N; l++) IN[l] = (j == pos[l]);
               cyc();
               cnt2 = $countones(OUT);
               ones += cnt2;
            end
         end
         if (m == 0) chk_int("density_mag", ones, 30400, 33600);
         else        chk_int("density_att", ones, 1600, 2400);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
